// File: rtl/xge_rx_aggregator.sv
// rtl/xge_rx_aggregator.sv - N-port xge MAC rx frame aggregator with round-robin frame arbiter.
// Optional per-port dropped-frame counters are built when XGE_RX_AGG_STATS_EN is defined.
module xge_rx_aggregator #(
  parameter int NUM_PORTS = 2,
  parameter int BUF_AW    = 10,
  parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    mac_clk,
  input  logic                    mac_rst,
  input  logic [64*NUM_PORTS-1:0] mac_rx_data,
  input  logic [8*NUM_PORTS-1:0]  mac_rx_data_valid,
  input  logic [NUM_PORTS-1:0]    mac_rx_good_frame,
  input  logic [NUM_PORTS-1:0]    mac_rx_bad_frame,
  output logic [63:0]             out_data,
  output logic [7:0]              out_data_valid,
  output logic                    out_last,
  output logic [PW-1:0]           out_port,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NUM_PORTS-1:0] drop_cnt
);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SEND  = 1'b1;
  localparam int              BW       = 73;
  localparam logic [BUF_AW:0] FULL_CNT = {1'b1, {BUF_AW{1'b0}}};

  logic [NUM_PORTS-1:0] w_fcnt_nz;
  logic [NUM_PORTS-1:0] w_rd_inc;
  logic [NUM_PORTS-1:0] w_pop_port;
  logic [BW-1:0]        w_rd_word [NUM_PORTS];
  logic [BW-1:0]        w_cur_word;

  logic [0:0]    r_state;
  logic [PW-1:0] r_cur_port;
  logic [PW-1:0] r_last_port;
  logic [PW-1:0] w_sel;
  logic          w_found;
  logic          r_fetch_done;
  logic          w_load;
  logic          w_pop;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [BW-1:0]   r_mem [2**BUF_AW];
    logic [63:0]     r_stg_data;
    logic [7:0]      r_stg_dv;
    logic            r_stg_vld;
    logic            r_drop;
    logic [BUF_AW:0] r_wr_ptr;
    logic [BUF_AW:0] r_commit_ptr;
    logic [BUF_AW:0] r_rd_ptr;
    logic [BUF_AW:0] r_frame_cnt;

    logic [63:0] w_in_data;
    logic [7:0]  w_in_dv;
    logic        w_beat;
    logic        w_active;
    logic        w_good;
    logic        w_bad;
    logic        w_full;
    logic        w_need_wr;
    logic        w_wr;
    logic        w_ovf;
    logic        w_commit;

    assign w_in_data = mac_rx_data[64*p +: 64];
    assign w_in_dv   = mac_rx_data_valid[8*p +: 8];
    assign w_beat    = |w_in_dv;
    // A frame end only counts if something arrived since the previous end.
    assign w_active  = r_stg_vld | r_drop;
    assign w_bad     = mac_rx_bad_frame[p] & w_active;
    assign w_good    = mac_rx_good_frame[p] & ~mac_rx_bad_frame[p] & w_active;
    assign w_full    = (r_wr_ptr - r_rd_ptr) == FULL_CNT;
    // A beat coinciding with a frame end is the first beat of the next frame.
    assign w_need_wr = r_stg_vld & ~w_bad & (w_good | w_beat);
    assign w_ovf     = w_need_wr & ~r_drop & w_full;
    assign w_wr      = w_need_wr & ~r_drop & ~w_full;
    assign w_commit  = w_good & w_wr;

    assign w_fcnt_nz[p] = |r_frame_cnt;
    assign w_rd_word[p] = r_mem[r_rd_ptr[BUF_AW-1:0]];

    always_ff @(posedge mac_clk) begin
      if (w_wr) begin
        r_mem[r_wr_ptr[BUF_AW-1:0]] <= {w_good, r_stg_dv, r_stg_data};
      end
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
        r_stg_data   <= '0;
        r_stg_dv     <= '0;
        r_stg_vld    <= 1'b0;
        r_drop       <= 1'b0;
        r_wr_ptr     <= '0;
        r_commit_ptr <= '0;
      end else begin
        if (w_good || w_bad) begin
          if (w_commit) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_commit_ptr <= r_wr_ptr + 1'b1;
          end else begin
            r_wr_ptr <= r_commit_ptr;
          end
          r_drop    <= 1'b0;
          r_stg_vld <= w_beat;
        end else begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (w_ovf) begin
            r_drop <= 1'b1;
          end
          if (w_beat) begin
            r_stg_vld <= 1'b1;
          end
        end
        if (w_beat) begin
          r_stg_data <= w_in_data;
          r_stg_dv   <= w_in_dv;
        end
      end
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
        r_rd_ptr    <= '0;
        r_frame_cnt <= '0;
      end else begin
        if (w_rd_inc[p]) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_commit && !w_pop_port[p]) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else if (!w_commit && w_pop_port[p]) begin
          r_frame_cnt <= r_frame_cnt - 1'b1;
        end
      end
    end

`ifdef XGE_RX_AGG_STATS_EN
    logic        w_drop_evt;
    logic [31:0] r_drop_cnt;

    assign w_drop_evt = (w_good | w_bad) & (r_drop | w_ovf);

    always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
        r_drop_cnt <= '0;
      end else if (w_drop_evt && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end

    assign drop_cnt[32*p +: 32] = r_drop_cnt;
`else
    assign drop_cnt[32*p +: 32] = 32'd0;
`endif
  end

  // Round-robin scan: the port closest after last_port wins, so iterate farthest first.
  always_comb begin
    logic [PW:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_sel   = r_last_port;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      v_idx = {1'b0, r_last_port} + (PW+1)'(i);
      if (v_idx >= (PW+1)'(NUM_PORTS)) begin
        v_idx = v_idx - (PW+1)'(NUM_PORTS);
      end
      if (w_fcnt_nz[v_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = v_idx[PW-1:0];
      end
    end
  end

  assign w_cur_word = w_rd_word[r_cur_port];
  assign w_load     = (r_state == ST_SEND) && !r_fetch_done && (!out_valid || out_ready);
  assign w_pop      = out_valid && out_ready && out_last;

  always_comb begin
    w_rd_inc   = '0;
    w_pop_port = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rd_inc[p]   = w_load && (r_cur_port == PW'(p));
      w_pop_port[p] = w_pop && (r_cur_port == PW'(p));
    end
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      r_state        <= ST_IDLE;
      r_cur_port     <= '0;
      r_last_port    <= PW'(NUM_PORTS - 1);
      r_fetch_done   <= 1'b0;
      out_data       <= '0;
      out_data_valid <= '0;
      out_last       <= 1'b0;
      out_port       <= '0;
      out_valid      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_cur_port   <= w_sel;
            r_fetch_done <= 1'b0;
            r_state      <= ST_SEND;
          end
        end
        default: begin
          // Fetching stops once the last beat sits in the output register.
          if (w_load) begin
            out_data       <= w_cur_word[63:0];
            out_data_valid <= w_cur_word[71:64];
            out_last       <= w_cur_word[72];
            out_port       <= r_cur_port;
            out_valid      <= 1'b1;
            r_fetch_done   <= w_cur_word[72];
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (w_pop) begin
            r_last_port <= r_cur_port;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/xge_rx_aggregator.md
# xge_rx_aggregator

Parametrised N-port receive aggregator that sits between `NUM_PORTS` xge_intf MAC receive interfaces and the single DMA receive path, all in the `mac_clk` domain. Each port has its own frame buffer. A frame is committed on `good_frame` and rolled back on `bad_frame` or on overflow. Committed frames are forwarded whole, never interleaved, on one valid/ready stream tagged with the source port, with round-robin arbitration between ports.

## Interface
- `NUM_PORTS`, default 2: number of MAC rx ports, 1..4.
- `BUF_AW`, default 10: per-port buffer address width; 2^BUF_AW entries of 64-bit data, 8-bit valid and a last flag.
- `PW`, default `$clog2(NUM_PORTS)`, minimum 1: port tag width.

Ports:
- `mac_clk`  in  1: the only clock.
- `mac_rst`  in  1: reset; **asynchronous, active-high**.
- `mac_rx_data`  in  64*NUM_PORTS: port p occupies bits [64p+63:64p].
- `mac_rx_data_valid`  in  8*NUM_PORTS: byte enables, port p occupies bits [8p+7:8p].
- `mac_rx_good_frame`  in  NUM_PORTS: end of frame, frame OK.
- `mac_rx_bad_frame`  in  NUM_PORTS: end of frame, frame bad.
- `out_data`  out  64: frame beat.
- `out_data_valid`  out  8: byte enables of the beat.
- `out_last`  out  1: last beat of the frame.
- `out_port`  out  PW: source port of the frame.
- `out_valid`  out  1: beat present.
- `out_ready`  in  1: downstream accepts the beat.
- `drop_cnt`  out  32*NUM_PORTS: per-port dropped-frame counters; see Configuration.

## Operation
- **Write side**, independent per port:
  - A beat is a cycle with `data_valid != 0`.
  - Each beat is held in a staging register. When the next beat arrives, the staged beat is written with last=0.
  - On `good_frame`, the staged beat is written with last=1 and the frame is committed: `commit_ptr <= wr_ptr+1` and `frame_cnt` increments.
- **Rollback**: `bad_frame` discards the staged beat and sets `wr_ptr <= commit_ptr`.
- `good_frame` or `bad_frame` with no beat since the previous frame end is ignored.
- **Overflow**: a write when the buffer holds 2^BUF_AW entries sets the port's drop flag. The rest of the frame is discarded. At `good_frame` or `bad_frame` the frame is rolled back and counted as dropped.
  - A frame longer than 2^BUF_AW beats is therefore always dropped.
- Only `good_frame` frames that are not dropped are ever forwarded. `bad_frame` frames are not counted as drops.
- Pointers are BUF_AW+1 bits wide, so full and empty are distinguished by the MSB. The read side sees only committed entries.
- **Arbiter FSM**:
  - IDLE: scan the ports starting at `last_port+1` mod NUM_PORTS. Select the first port with `frame_cnt > 0`, latch it as `cur_port`, go to SEND.
  - SEND: stream `cur_port`'s buffer. On accepting the beat with `out_last`, decrement `frame_cnt[cur_port]`, set `last_port <= cur_port`, return to IDLE.
- A commit and a pop on the same port in the same cycle leave `frame_cnt` unchanged.
- A new frame on a port may be written while that port is being read.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `out_data_valid`=0, `out_port`=0, `drop_cnt`=0.
- Reset also clears all pointers, `frame_cnt`, the drop flags and the staging registers, sets `last_port`=NUM_PORTS-1 and puts the FSM in IDLE.
- Reset in mid-frame abandons both the partial input frames and the partial output frame.
- Outputs are registered.
- Latency: the first beat of a frame appears on `out_valid` at most 3 cycles after `good_frame` when the arbiter is idle.
- Handshake:
  - `out_data`, `out_data_valid`, `out_last` and `out_port` hold stable while `out_valid && !out_ready`.
  - `out_valid` does not depend combinationally on `out_ready`.
- Throughput: with `out_ready`=1, beats within a frame are back-to-back. There are at most 2 idle cycles between frames.
- `good_frame` and `bad_frame` are never asserted together. If they are, `bad_frame` wins.

## Configuration
- `XGE_RX_AGG_STATS_EN` defined: `drop_cnt[32p+31:32p]` counts the dropped frames of port p, +1 per dropped frame and saturating at 0xFFFFFFFF.
- Macro not defined: the counters are not built and `drop_cnt` is tied to 0. All forwarding behaviour is identical with and without the macro.

## Test plan
- NUM_PORTS=2, one 8-beat frame on port 0 with last beat `data_valid`=0x0F, then `good_frame`, `out_ready`=1 → 8 beats, `out_last` on beat 8 with `data_valid`=0x0F, `out_port`=0, data identical.
- A 5-beat frame on port 1 ending in `bad_frame`, then a 3-beat good frame → only the 3-beat frame is output; `drop_cnt` remains 0.
- Good frames committed on both ports in the same cycle, repeated 4 times → output order alternates between the ports (port 0 first after reset), with no interleaving within a frame.
- BUF_AW=4: a 20-beat good frame → not output, `drop_cnt[31:0]`=1; a following 4-beat frame is output intact.
- `out_ready` toggled at random 50% during a 10-beat frame → output signals are stable during stalls and all 10 beats arrive in order.
- `mac_rst` pulsed in the middle of an output frame → `out_valid`=0 immediately; after release, only frames received after reset are output.
